// File: rtl/hash_request_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// hash_request_scheduler_pkg
// Shared definitions for the hash request scheduler slice.
//   op_t      : 2-bit operation code carried from requesters to the controller
//   status_t  : 4-bit status {key_already_present, no_element_found,
//               no_write_space, no_deletion_target}
//   state_t   : scheduler FSM states
// ---------------------------------------------------------------------------
package hash_request_scheduler_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_NOTHING = 2'b00;
    localparam op_t OP_READ    = 2'b01;
    localparam op_t OP_WRITE   = 2'b10;
    localparam op_t OP_DELETE  = 2'b11;

    typedef logic [3:0] status_t;

    localparam status_t STATUS_OK = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/hash_request_scheduler_if.sv
// ---------------------------------------------------------------------------
// hash_request_scheduler_if
// Bundles the requester handshake, the table/controller side and busy.
//   req_valid_i/req_ready_o/req_op_i/req_key_i/req_data_i : per-port requests
//   rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_status_o       : per-port responses
//   tbl_key_o/tbl_data_o/tbl_lookup_o/tbl_op_o            : table operands
//   ctl_read_data_i/ctl_status_i                          : controller results
//   busy_o                                                : transaction active
// slave  : the scheduler's view; master : the surrounding system's view.
// ---------------------------------------------------------------------------
interface hash_request_scheduler_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int KEY_WIDTH      = 2,
    parameter int DATA_WIDTH     = 32
);
    import hash_request_scheduler_pkg::*;

    logic [NUM_REQUESTERS-1:0]                 req_valid_i;
    logic [NUM_REQUESTERS-1:0]                 req_ready_o;
    logic [NUM_REQUESTERS-1:0][1:0]            req_op_i;
    logic [NUM_REQUESTERS-1:0][KEY_WIDTH-1:0]  req_key_i;
    logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQUESTERS-1:0]                 rsp_valid_o;
    logic [NUM_REQUESTERS-1:0]                 rsp_ready_i;
    logic [DATA_WIDTH-1:0]                     rsp_data_o;
    status_t                                   rsp_status_o;
    logic [KEY_WIDTH-1:0]                      tbl_key_o;
    logic [DATA_WIDTH-1:0]                     tbl_data_o;
    logic                                      tbl_lookup_o;
    op_t                                       tbl_op_o;
    logic [DATA_WIDTH-1:0]                     ctl_read_data_i;
    status_t                                   ctl_status_i;
    logic                                      busy_o;

    modport slave (
        input  req_valid_i, req_op_i, req_key_i, req_data_i, rsp_ready_i,
               ctl_read_data_i, ctl_status_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o,
               tbl_key_o, tbl_data_o, tbl_lookup_o, tbl_op_o, busy_o
    );

    modport master (
        output req_valid_i, req_op_i, req_key_i, req_data_i, rsp_ready_i,
               ctl_read_data_i, ctl_status_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o,
               tbl_key_o, tbl_data_o, tbl_lookup_o, tbl_op_o, busy_o
    );

endinterface

// File: rtl/hash_request_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick.
//   i_req       : request vector
//   i_lastGrant : index of the most recently served requester
//   o_grant     : one-hot winner (zero when nothing requests)
//   o_grantIdx  : binary index of the winner
// Search starts one past i_lastGrant and wraps around.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_lastGrant,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grantIdx
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    // Walk the ports in rotated order; the first requesting one wins.
    always_comb begin
        o_grant    = '0;
        o_grantIdx = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = IW'((int'(i_lastGrant) + i) % N);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grantIdx     = w_idx;
            end
        end
    end

endmodule

// File: rtl/hash_request_scheduler.sv
// ---------------------------------------------------------------------------
// hash_request_scheduler
// Serialises requests from NUM_REQUESTERS ports onto a single hash table
// controller, one transaction at a time: grant -> FETCH (table read latency)
// -> EXEC (one-cycle op to controller) -> RESP (hold until consumed).
//   clk    : clock
//   reset  : asynchronous active-low reset
//   clk_en : global clock enable, low freezes all state
//   bus    : hash_request_scheduler_if.slave (requests, responses, table)
// ---------------------------------------------------------------------------
module hash_request_scheduler
    import hash_request_scheduler_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int KEY_WIDTH      = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int LOOKUP_LATENCY = 2
) (
    input logic                     clk,
    input logic                     reset,
    input logic                     clk_en,
    hash_request_scheduler_if.slave bus
);

    localparam int IW = $clog2(NUM_REQUESTERS);
    localparam int CW = $clog2(LOOKUP_LATENCY + 1);
    // FETCH lasts LOOKUP_LATENCY-1 cycles, so the counter leaves at LL-2.
    localparam logic [CW-1:0] FETCH_LAST = CW'((LOOKUP_LATENCY > 1) ? LOOKUP_LATENCY - 2 : 0);

    state_t                  r_state;
    state_t                  w_nextState;
    logic [IW-1:0]           r_lastGrant;
    logic [IW-1:0]           r_grantIdx;
    logic [CW-1:0]           r_fetchCnt;
    op_t                     r_op;
    logic [KEY_WIDTH-1:0]    r_key;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_rspData;
    status_t                 r_rspStatus;
    logic [NUM_REQUESTERS-1:0] w_arbGrant;
    logic [IW-1:0]           w_arbIdx;
    logic                    w_grantCycle;
    logic                    w_rspDone;

    rr_arbiter #(.N(NUM_REQUESTERS)) u_arbiter (
        .i_req       (bus.req_valid_i),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_arbGrant),
        .o_grantIdx  (w_arbIdx)
    );

    // The reset term keeps ready/lookup low while reset is held, since the
    // state register already sits in IDLE during reset.
    assign w_grantCycle = reset && clk_en && (r_state == ST_IDLE) && (|bus.req_valid_i);
    assign w_rspDone    = clk_en && (r_state == ST_RESP) && bus.rsp_ready_i[r_grantIdx];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else if (clk_en) begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (w_grantCycle) w_nextState = (LOOKUP_LATENCY == 1) ? ST_EXEC : ST_FETCH;
            ST_FETCH: if (r_fetchCnt == FETCH_LAST) w_nextState = ST_EXEC;
            ST_EXEC:  w_nextState = ST_RESP;
            ST_RESP:  if (bus.rsp_ready_i[r_grantIdx]) w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Output logic. The table key/data are bypassed from the winner during
    // the grant cycle so they line up with the lookup pulse.
    always_comb begin
        bus.req_ready_o  = w_grantCycle ? w_arbGrant : '0;
        bus.tbl_lookup_o = w_grantCycle;
        bus.tbl_key_o    = w_grantCycle ? bus.req_key_i[w_arbIdx]  : r_key;
        bus.tbl_data_o   = w_grantCycle ? bus.req_data_i[w_arbIdx] : r_data;
        bus.tbl_op_o     = ((r_state == ST_EXEC) && clk_en) ? r_op : OP_NOTHING;
        bus.busy_o       = (r_state != ST_IDLE);
        bus.rsp_valid_o  = '0;
        if (r_state == ST_RESP) begin
            bus.rsp_valid_o[r_grantIdx] = 1'b1;
        end
        bus.rsp_data_o   = r_rspData;
        bus.rsp_status_o = r_rspStatus;
    end

    // Transaction datapath: latch the winner, run the fetch counter, capture
    // the controller result, and advance the round-robin pointer on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lastGrant <= IW'(NUM_REQUESTERS - 1);
            r_grantIdx  <= '0;
            r_fetchCnt  <= '0;
            r_op        <= OP_NOTHING;
            r_key       <= '0;
            r_data      <= '0;
            r_rspData   <= '0;
            r_rspStatus <= STATUS_OK;
        end else if (clk_en) begin
            if (w_grantCycle) begin
                r_op       <= bus.req_op_i[w_arbIdx];
                r_key      <= bus.req_key_i[w_arbIdx];
                r_data     <= bus.req_data_i[w_arbIdx];
                r_grantIdx <= w_arbIdx;
            end
            if (r_state == ST_FETCH) begin
                r_fetchCnt <= (r_fetchCnt == FETCH_LAST) ? '0 : r_fetchCnt + CW'(1);
            end
            if (r_state == ST_EXEC) begin
                r_rspData   <= bus.ctl_read_data_i;
                r_rspStatus <= (r_op == OP_NOTHING) ? STATUS_OK : bus.ctl_status_i;
            end
            if (w_rspDone) begin
                r_lastGrant <= r_grantIdx;
            end
        end
    end

endmodule
